// File: rtl/ps2_scancode_receiver_if.sv
// Read-side bundle between the PS/2 scan-code receiver and the input-select logic.
// The reader is the master; the receiver sits on the slave modport.
interface ps2_scancode_receiver_if #(
    parameter int ADDR_W = 3
) ();
    logic              rd_en;
    logic              clear_err;
    logic [9:0]        rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic              parity_err;

    modport master (
        output rd_en, clear_err,
        input  rd_data, rd_valid, fifo_count, overflow, parity_err
    );

    modport slave (
        input  rd_en, clear_err,
        output rd_data, rd_valid, fifo_count, overflow, parity_err
    );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: synchronizes and filters the PS/2 lines, folds E0/F0
// prefixes into flag bits and queues {ext, brk, code} entries in a show-ahead FIFO.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int ADDR_W         = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ps2_clk_in,
    input  logic                   ps2_data_in,
    ps2_scancode_receiver_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [1:0]        r_clk_sync;
    logic [1:0]        r_dat_sync;
    logic              r_filt_clk;
    logic [FILT_W-1:0] r_filt_cnt;
    logic              w_clk_s;
    logic              w_dat_s;
    logic              w_flip;
    logic              w_fall;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];
    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    assign w_flip  = (w_clk_s != r_filt_clk) && (r_filt_cnt == FILT_LAST);
    assign w_fall  = w_flip && r_filt_clk;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_data_in};
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (w_flip) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    logic [2:0]      r_state;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_parity;
    logic            r_stop;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext_pend;
    logic            r_brk_pend;
    logic            w_check;
    logic            w_frame_ok;
    logic            w_push;

    assign w_check    = (r_state == S_CHECK);
    assign w_frame_ok = r_stop && (^{r_shift, r_parity});
    assign w_push     = w_check && w_frame_ok && (r_shift != 8'hE0) && (r_shift != 8'hF0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_stop     <= 1'b0;
            r_to_cnt   <= '0;
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + 1'b1;

            // A stalled frame is dropped silently; pending prefixes survive it.
            if (r_state != S_IDLE && !w_fall && r_to_cnt == TO_LAST) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (w_fall && !w_dat_s) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                    S_DATA: if (w_fall) begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: if (w_fall) begin
                        r_parity <= w_dat_s;
                        r_state  <= S_STOP;
                    end
                    S_STOP: if (w_fall) begin
                        r_stop  <= w_dat_s;
                        r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        r_state <= S_IDLE;
                        if (!w_frame_ok || w_push) begin
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                        end else if (r_shift == 8'hE0) begin
                            r_ext_pend <= 1'b1;
                        end else begin
                            r_brk_pend <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    logic [9:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_parity_err;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_pop   = bus.rd_en && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    // NOTE: storage has no reset; emptiness is tracked by r_count and rd_data is masked.
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_ext_pend, r_brk_pend, r_shift};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (bus.clear_err)         r_overflow <= 1'b0;
            if (w_check && !w_frame_ok)     r_parity_err <= 1'b1;
            else if (bus.clear_err)         r_parity_err <= 1'b0;
        end
    end

    assign bus.rd_valid   = !w_empty;
    assign bus.rd_data    = w_empty ? 10'h000 : r_mem[r_rd_ptr];
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.parity_err = r_parity_err;
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Randomized and directed bench for ps2_scancode_receiver, checked against a queue model
// that applies the frame/prefix/FIFO rules directly to whole scan-code bytes.
module tb_ps2_scancode_receiver;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int FIFO_DEPTH     = 8;
    localparam int ADDR_W         = 3;
    localparam int HALF           = 20;

    logic clock       = 1'b0;
    logic reset_n     = 1'b0;
    logic ps2_clk_in  = 1'b1;
    logic ps2_data_in = 1'b1;

    ps2_scancode_receiver_if #(.ADDR_W(ADDR_W)) bus ();

    ps2_scancode_receiver #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .bus        (bus)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int latency  = 0;

    logic [9:0] m_q [$];
    bit m_ext, m_brk, m_ovf, m_perr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [9:0] exp_data;
        exp_data = (m_q.size() != 0) ? m_q[0] : 10'h000;
        check({tag, "/count"},  32'(bus.fifo_count), 32'(m_q.size()));
        check({tag, "/valid"},  32'(bus.rd_valid),   32'(m_q.size() != 0));
        check({tag, "/data"},   32'(bus.rd_data),    32'(exp_data));
        check({tag, "/ovf"},    32'(bus.overflow),   32'(m_ovf));
        check({tag, "/perr"},   32'(bus.parity_err), 32'(m_perr));
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_perr = 1'b1;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back({m_ext, m_brk, b});
            else                         m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic ps2_bit(input logic b);
        @(posedge clock);
        ps2_data_in = b;
        repeat (HALF) @(posedge clock);
        ps2_clk_in = 1'b0;
        repeat (HALF) @(posedge clock);
        ps2_clk_in = 1'b1;
    endtask

    // Stop bit's low phase doubles as an observation window counted in clock edges.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int pop_at, input bit measure, input bit hold_clr);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (hold_clr) bus.clear_err = 1'b1;
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(posedge clock);
        ps2_data_in = bits[10];
        repeat (HALF) @(posedge clock);
        ps2_clk_in = 1'b0;
        for (int c = 1; c < HALF; c++) begin
            @(posedge clock);
            @(negedge clock);
            bus.rd_en = (pop_at > 1 && c == pop_at - 1);
            if (measure && latency == 0 && bus.rd_valid) latency = c;
            if (hold_clr && bus.parity_err) bus.clear_err = 1'b0;
        end
        @(posedge clock);
        ps2_clk_in    = 1'b1;
        ps2_data_in   = 1'b1;
        bus.rd_en     = 1'b0;
        bus.clear_err = 1'b0;
        repeat (HALF) @(posedge clock);
        if (pop_at > 1 && m_q.size() != 0) void'(m_q.pop_front());
        if (hold_clr) begin
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end
        model_frame(b, !bad_par && !bad_stop);
        @(negedge clock);
    endtask

    task automatic frame(input logic [7:0] b, input string tag);
        send_frame(b, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check_state(tag);
    endtask

    task automatic do_read(input string tag);
        @(negedge clock);
        bus.rd_en = 1'b1;
        @(negedge clock);
        bus.rd_en = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        check_state(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clock);
        bus.clear_err = 1'b1;
        @(negedge clock);
        bus.clear_err = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        check_state(tag);
    endtask

    task automatic send_partial(input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)));
        ps2_data_in = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         act;
        bus.rd_en     = 1'b0;
        bus.clear_err = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_state("reset");
        reset_n = 1'b1;
        repeat (5) @(posedge clock);

        // Single frame, latency window, pop, pop on empty.
        send_frame(8'h1C, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        check_state("f1C");
        check("latency_window", 32'(latency >= 3 && latency <= HALF - 2), 32'd1);
        do_read("rd1C");
        do_read("rd_empty");
        frame(8'h33, "f33_after_empty_read");
        do_read("rd33");

        // Prefix folding.
        frame(8'hE0, "fE0");
        frame(8'hF0, "fF0");
        frame(8'h75, "f75");
        check("ext_brk_entry", 32'(bus.rd_data), 32'h375);
        frame(8'h1C, "f1C_after_prefix");
        do_read("rd375");
        do_read("rd01C");

        // Parity error, clear, and set-wins-over-clear.
        send_frame(8'h1C, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_state("bad_parity");
        do_clear("clr_perr");
        send_frame(8'h1C, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        check_state("perr_set_wins");
        do_clear("clr_perr2");

        // Overflow and ordered drain.
        for (int i = 1; i <= 9; i++) frame(8'(i), "fill");
        check("full_count", 32'(bus.fifo_count), 32'd8);
        for (int i = 0; i < 8; i++) do_read("drain_fill");
        for (int i = 0; i < 8; i++) frame(8'(8'h11 + i), "refill");
        do_clear("clr_ovf");
        send_frame(8'h0A, 1'b0, 1'b0, latency, 1'b0, 1'b0);
        check_state("push_pop_full");
        for (int i = 0; i < 8; i++) do_read("drain_refill");

        // Timeout abandons a partial frame.
        send_partial(4);
        repeat (TIMEOUT_CYCLES + 100) @(posedge clock);
        @(negedge clock);
        check_state("timeout");
        frame(8'h29, "f29_after_timeout");
        do_read("rd29");

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 3; i++) frame(8'(8'h40 + i), "prefill");
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("rst_async/count", 32'(bus.fifo_count), 32'd0);
        check("rst_async/valid", 32'(bus.rd_valid),   32'd0);
        check("rst_async/data",  32'(bus.rd_data),    32'd0);
        m_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_state("after_reset");
        frame(8'h5A, "f5A_after_reset");
        do_read("rd5A");

        // Short glitch on the PS/2 clock with data low must not start a frame.
        @(posedge clock);
        ps2_data_in = 1'b0;
        ps2_clk_in  = 1'b0;
        repeat (3) @(posedge clock);
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        repeat (20) @(posedge clock);
        frame(8'h42, "f42_after_glitch");
        do_read("rd42");

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            act = int'($urandom_range(0, 9));
            if (act < 6) begin
                case ($urandom_range(0, 9))
                    0:       b = 8'hE0;
                    1:       b = 8'hF0;
                    default: b = 8'($urandom);
                endcase
                send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                           0, 1'b0, 1'b0);
                check_state("rand_frame");
            end else if (act < 9) begin
                do_read("rand_read");
            end else begin
                do_clear("rand_clear");
            end
        end
        while (m_q.size() != 0) do_read("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
